// File: rtl/float_mul_seq.sv
// float_mul_seq: sequential shift-add IEEE-754 multiplier behind valid/ready handshakes.
// Define FLOAT_MUL_SEQ_ROUND_EN for round-to-nearest-even in NORM; otherwise the product is truncated.
module float_mul_seq #(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] in_a,
    input  logic [E+M:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] out_res,
    output logic         busy
);
    localparam int W  = 1 + E + M;
    localparam int PW = 2 * M + 2;
    localparam int CW = $clog2(M + 1);
`ifdef FLOAT_MUL_SEQ_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam logic [E+1:0]        BIAS_X = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EMAX   = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EZERO  = '0;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t        state_q;
    logic          sign_q;
    logic [E-1:0]  ea_q, eb_q;
    logic [PW-1:0] mcand_q, acc_q;
    logic [M:0]    mplier_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  out_res_q;
    logic          out_valid_q, in_ready_q, busy_q;

    // Operand classification (denormals count as zero)
    logic [E-1:0] a_exp, b_exp;
    logic [M-1:0] a_man, b_man;
    logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic         any_nan, any_inf, any_zero, is_special, in_sign;
    logic [W-1:0] special_res;

    assign a_exp    = in_a[W-2:M];
    assign b_exp    = in_b[W-2:M];
    assign a_man    = in_a[M-1:0];
    assign b_man    = in_b[M-1:0];
    assign a_zero   = (a_exp == '0);
    assign b_zero   = (b_exp == '0);
    assign a_inf    = (&a_exp) && (a_man == '0);
    assign b_inf    = (&b_exp) && (b_man == '0);
    assign a_nan    = (&a_exp) && (a_man != '0);
    assign b_nan    = (&b_exp) && (b_man != '0);
    assign any_nan  = a_nan | b_nan;
    assign any_inf  = a_inf | b_inf;
    assign any_zero = a_zero | b_zero;
    assign is_special = any_nan | any_inf | any_zero;
    assign in_sign  = in_a[W-1] ^ in_b[W-1];

    always_comb begin
        special_res = {in_sign, {(W-1){1'b0}}};
        if (any_nan || (any_inf && any_zero)) begin
            special_res = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        end else if (any_inf) begin
            special_res = {in_sign, {E{1'b1}}, {M{1'b0}}};
        end
    end

    // Normalization, optional rounding and range checks on the finished product
    logic                top, guard, sticky, round_up;
    logic [M-1:0]        frac_t, frac_f;
    logic [M:0]          frac_inc;
    logic signed [E+1:0] esum_t, esum_f;
    logic [W-1:0]        norm_res;

    always_comb begin
        top    = acc_q[PW-1];
        esum_t = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_X + {{(E+1){1'b0}}, top};
        if (top) begin
            frac_t = acc_q[2*M:M+1];
            guard  = acc_q[M];
            sticky = |acc_q[M-1:0];
        end else begin
            frac_t = acc_q[2*M-1:M];
            guard  = acc_q[M-1];
            sticky = |acc_q[M-2:0];
        end
        round_up = ROUND_EN && guard && (sticky || frac_t[0]);
        frac_inc = {1'b0, frac_t} + {{M{1'b0}}, 1'b1};
        frac_f   = frac_t;
        esum_f   = esum_t;
        if (round_up) begin
            frac_f = frac_inc[M-1:0];
            if (frac_inc[M]) begin
                esum_f = esum_t + (E+2)'(1);
            end
        end
        if (esum_f >= EMAX) begin
            norm_res = {sign_q, {E{1'b1}}, {M{1'b0}}};
        end else if (esum_f <= EZERO) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
        end else begin
            norm_res = {sign_q, esum_f[E-1:0], frac_f};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_res_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        ea_q       <= a_exp;
                        eb_q       <= b_exp;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (is_special) begin
                            out_res_q   <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mcand_q  <= {{(M+1){1'b0}}, 1'b1, a_man};
                            mplier_q <= {1'b1, b_man};
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == CW'(M)) begin
                        state_q <= NORM;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                NORM: begin
                    out_res_q   <= norm_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_float_mul_seq.sv
// Scoreboard bench for float_mul_seq: driver pushes expected results, a forked monitor
// pops and compares on each out_valid rise (value and accept-to-valid latency).
module tb_float_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_res;
    logic        busy;

    always #5 clk = ~clk;

    float_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

`ifdef FLOAT_MUL_SEQ_ROUND_EN
    localparam logic [31:0] RND_EXP = 32'h40100002;
`else
    localparam logic [31:0] RND_EXP = 32'h40100001;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, got, req);
        end
    endfunction

    task automatic monitor();
        logic prev_valid = 1'b0;
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %08h, required no result", out_res);
                    end else begin
                        e   = sb_q.pop_front();
                        lat = cyc - e.acc_cyc + 1;
                        $display("[TB] %s: %08h * %08h -> %08h (expect %08h) latency %0d (expect %0d)",
                                 e.name, e.a, e.b, out_res, e.res, lat, e.lat);
                        check({e.name, "_res"}, out_res, e.res);
                        check({e.name, "_lat"}, 32'(lat), 32'(e.lat));
                    end
                end
                prev_valid = out_valid;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input int lat, input string name);
        int   waitc = 0;
        exp_t e;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: got in_ready=0 after %0d cycles, required 1", name, waitc);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.a = a; e.b = b; e.res = r; e.lat = lat; e.acc_cyc = cyc; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((sb_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0 || busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: got pending=%0d busy=%0b, required 0 0", name, sb_q.size(), busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        fork
            monitor();
        join_none

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_res", out_res, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 26, "mul_1p5x2");
        issue(32'h00000000, 32'hC2F60000, 32'h80000000, 1,  "zero_x_neg");
        issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1,  "nan_x_one");
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 1,  "inf_x_zero");
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, 1,  "neginf_x_two");
        issue(32'h00000001, 32'h3F800000, 32'h00000000, 1,  "denorm_flush");
        issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 26, "overflow_big");
        issue(32'h7F000000, 32'h40000000, 32'h7F800000, 26, "overflow_edge");
        issue(32'h7F000000, 32'h3F800000, 32'h7F000000, 26, "max_exp_keep");
        issue(32'h00800000, 32'h00800000, 32'h00000000, 26, "underflow_small");
        issue(32'h00800000, 32'h3F000000, 32'h00000000, 26, "underflow_edge");
        issue(32'h00800000, 32'h3F800000, 32'h00800000, 26, "min_normal_keep");
        issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 26, "neg2_x_3");
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 26, "carry_1p5sq");
        issue(32'h3FC00001, 32'h3FC00001, RND_EXP,      26, "round_case");
        drain("directed");

        // Consumer stall: result must hold and extra in_valid must be ignored
        out_ready = 1'b0;
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, 26, "stall_op");
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_valid_seen", 32'(out_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            in_a     = 32'h3F800000;
            in_b     = 32'h3F800000;
            in_valid = 1'b1;
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_out_res", out_res, 32'h40400000);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(out_valid), 32'h0);
        check("release_in_ready", 32'(in_ready), 32'h1);
        repeat (3) @(negedge clk);
        check("release_idle", 32'(busy), 32'h0);
        drain("stall");

        // Abort in the middle of MUL
        @(negedge clk);
        in_a     = 32'h3FC00000;
        in_b     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("abort_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'h1);
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_out_res", out_res, 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 26, "after_abort");
        drain("after_abort");
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
